// File: rtl/y86_uop_seq.sv
// Y86 micro-op sequencer: holds one instruction and expands POPL (and LEAVE when
// Y86_LEAVE_EN is defined) into register-file micro-ops; everything else passes through.
module y86_uop_seq #(
    parameter logic [4:0] REG_OFS   = 5'd1,
    parameter logic [4:0] R_ESP_IDX = 5'd5,
    parameter logic [4:0] R_EBP_IDX = 5'd6,
    parameter logic [3:0] OP_LEAVE  = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [47:0] inst,
    input  logic [31:0] next_inst_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  uop_idx,
    output logic        uop_last,
    output logic        passthru,
    output logic [4:0]  ra,
    output logic [4:0]  rn,
    output logic [3:0]  aluc,
    output logic [31:0] imm,
    output logic        useimm,
    output logic        m2reg,
    output logic        wreg,
    output logic [31:0] held_pc
);
    localparam logic [3:0] OP_POPL = 4'hB;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0101;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  uop_idx_q, uop_idx_d;
    logic        mode_q, mode_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  rsrc_q, rsrc_d;
    logic [31:0] pc_q, pc_d;

    // Only the opcode and rA nibbles steer the expansion.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst[47:16], inst[11:8], inst[3:0]};

    logic [4:0] rn_a;
    logic       is_popl, popl_esp, hs, accept;
    logic [1:0] last_idx;

    assign rn_a     = {1'b0, rsrc_q} + REG_OFS;
    assign is_popl  = mode_q && (op_q == OP_POPL);
    assign popl_esp = is_popl && (rn_a == R_ESP_IDX);

`ifdef Y86_LEAVE_EN
    logic is_leave;
    assign is_leave = mode_q && (op_q == OP_LEAVE) && !is_popl;
    assign last_idx = (is_popl && !popl_esp) ? 2'd1 : (is_leave ? 2'd2 : 2'd0);
`else
    logic [8:0] unused_leave_cfg;
    assign unused_leave_cfg = {OP_LEAVE, R_EBP_IDX};
    assign last_idx = (is_popl && !popl_esp) ? 2'd1 : 2'd0;
`endif

    assign out_valid = (state_q == ISSUE);
    assign uop_idx   = uop_idx_q;
    assign uop_last  = out_valid && (uop_idx_q == last_idx);
    assign in_ready  = (state_q == IDLE) || (out_ready && uop_last);
    assign hs        = out_valid && out_ready;
    assign accept    = in_valid && in_ready;
    assign held_pc   = pc_q;

    always_comb begin
        passthru = 1'b0;
        ra       = 5'd0;
        rn       = 5'd0;
        aluc     = 4'd0;
        imm      = 32'd0;
        useimm   = 1'b0;
        m2reg    = 1'b0;
        wreg     = 1'b0;
        if (state_q == ISSUE) begin
            if (is_popl) begin
                if (uop_idx_q == 2'd0) begin
                    ra = R_ESP_IDX; rn = rn_a; aluc = ALU_OR;
                    useimm = 1'b1; m2reg = 1'b1; wreg = 1'b1;
                end else begin
                    ra = R_ESP_IDX; rn = R_ESP_IDX; aluc = ALU_ADD;
                    imm = 32'd4; useimm = 1'b1; wreg = 1'b1;
                end
`ifdef Y86_LEAVE_EN
            end else if (is_leave) begin
                case (uop_idx_q)
                    2'd0: begin
                        ra = R_EBP_IDX; rn = R_ESP_IDX; aluc = ALU_OR;
                        useimm = 1'b1; wreg = 1'b1;
                    end
                    2'd1: begin
                        ra = R_ESP_IDX; rn = R_EBP_IDX; aluc = ALU_OR;
                        useimm = 1'b1; m2reg = 1'b1; wreg = 1'b1;
                    end
                    default: begin
                        ra = R_ESP_IDX; rn = R_ESP_IDX; aluc = ALU_ADD;
                        imm = 32'd4; useimm = 1'b1; wreg = 1'b1;
                    end
                endcase
`endif
            end else begin
                passthru = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        uop_idx_d = uop_idx_q;
        mode_d    = mode_q;
        op_d      = op_q;
        rsrc_d    = rsrc_q;
        pc_d      = pc_q;
        if (hs) begin
            if (uop_last) begin
                state_d   = IDLE;
                uop_idx_d = 2'd0;
            end else begin
                uop_idx_d = uop_idx_q + 2'd1;
            end
        end
        // Accept on the same edge as the last handshake gives zero-bubble issue.
        if (accept) begin
            state_d   = ISSUE;
            uop_idx_d = 2'd0;
            mode_d    = mode;
            op_d      = inst[7:4];
            rsrc_d    = inst[15:12];
            pc_d      = next_inst_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            uop_idx_q <= 2'd0;
            mode_q    <= 1'b0;
            op_q      <= 4'd0;
            rsrc_q    <= 4'd0;
            pc_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            uop_idx_q <= uop_idx_d;
            mode_q    <= mode_d;
            op_q      <= op_d;
            rsrc_q    <= rsrc_d;
            pc_q      <= pc_d;
        end
    end
endmodule

// File: tb/tb_y86_uop_seq.sv
// Randomized bench for y86_uop_seq: a per-instruction micro-op list model plus
// directed literal checks for the named scenarios.
module tb_y86_uop_seq;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0101;
`ifdef Y86_LEAVE_EN
    localparam bit LEAVE_ON = 1'b1;
`else
    localparam bit LEAVE_ON = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, mode = 1'b0;
    logic [47:0] inst = '0;
    logic [31:0] next_inst_pc = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [1:0]  uop_idx;
    logic        uop_last, passthru;
    logic [4:0]  ra, rn;
    logic [3:0]  aluc;
    logic [31:0] imm;
    logic        useimm, m2reg, wreg;
    logic [31:0] held_pc;

    y86_uop_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .inst(inst), .next_inst_pc(next_inst_pc),
        .out_valid(out_valid), .out_ready(out_ready), .uop_idx(uop_idx),
        .uop_last(uop_last), .passthru(passthru), .ra(ra), .rn(rn),
        .aluc(aluc), .imm(imm), .useimm(useimm), .m2reg(m2reg), .wreg(wreg),
        .held_pc(held_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  idx;
        logic        pt;
        logic [4:0]  ra, rn;
        logic [3:0]  aluc;
        logic [31:0] imm;
        logic        useimm, m2reg, wreg;
    } uop_t;

    uop_t        q[$];
    logic [31:0] pc_m = '0;
    int          checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic uop_t mk(input logic [1:0] idx, input logic pt, input logic [4:0] a,
                                input logic [4:0] n, input logic [3:0] c, input logic [31:0] im,
                                input logic ui, input logic mr, input logic wr);
        uop_t u;
        u.idx = idx; u.pt = pt; u.ra = a; u.rn = n; u.aluc = c; u.imm = im;
        u.useimm = ui; u.m2reg = mr; u.wreg = wr;
        return u;
    endfunction

    // Expected micro-op list for one instruction, straight from the expansion rules.
    task automatic load(input logic md, input logic [47:0] in);
        logic [3:0] op;
        logic [4:0] dst;
        op  = in[7:4];
        dst = 5'(in[15:12] + 5'd1);
        if (md && op == 4'hB) begin
            q.push_back(mk(0, 0, 5, dst, ALU_OR, 0, 1, 1, 1));
            if (dst != 5'd5) q.push_back(mk(1, 0, 5, 5, ALU_ADD, 4, 1, 0, 1));
        end else if (md && op == 4'hF && LEAVE_ON) begin
            q.push_back(mk(0, 0, 6, 5, ALU_OR, 0, 1, 0, 1));
            q.push_back(mk(1, 0, 5, 6, ALU_OR, 0, 1, 1, 1));
            q.push_back(mk(2, 0, 5, 5, ALU_ADD, 4, 1, 0, 1));
        end else begin
            q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            pc_m <= '0;
        end else begin
            if (in_valid && (q.size() == 0 || (out_ready && q.size() == 1))) begin
                q.delete();
                load(mode, inst);
                pc_m <= next_inst_pc;
            end else if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() == 0 || (out_ready && q.size() == 1)));
        chk("held_pc", held_pc, pc_m);
        if (q.size() != 0) begin
            chk("uop_idx", 32'(uop_idx), 32'(q[0].idx));
            chk("uop_last", 32'(uop_last), 32'(q.size() == 1));
            chk("passthru", 32'(passthru), 32'(q[0].pt));
            if (!q[0].pt) begin
                chk("ra", 32'(ra), 32'(q[0].ra));
                chk("rn", 32'(rn), 32'(q[0].rn));
                chk("aluc", 32'(aluc), 32'(q[0].aluc));
                chk("imm", imm, q[0].imm);
                chk("useimm", 32'(useimm), 32'(q[0].useimm));
                chk("m2reg", 32'(m2reg), 32'(q[0].m2reg));
                chk("wreg", 32'(wreg), 32'(q[0].wreg));
            end
        end
    end

    task automatic cyc(input logic r, input logic iv, input logic md, input logic [47:0] in,
                       input logic [31:0] pc, input logic ordy);
        @(posedge clk);
        #1;
        reset = r; in_valid = iv; mode = md; inst = in; next_inst_pc = pc; out_ready = ordy;
        #2;
    endtask

    localparam logic [47:0] MIPS_ADD  = 48'h0000_0232_0820;
    localparam logic [47:0] POPL_EAX  = 48'h0000_0000_0FB0;
    localparam logic [47:0] POPL_ECX  = 48'h0000_0000_1FB0;
    localparam logic [47:0] POPL_ESP  = 48'h0000_0000_4FB0;
    localparam logic [47:0] Y86_NOP   = 48'h0000_0000_0010;
    localparam logic [47:0] Y86_LEAVE = 48'h0000_0000_00F0;

    initial begin
        logic [47:0] x;
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_uop_idx", 32'(uop_idx), 0);
        chk("rst_held_pc", held_pc, 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst_in_ready", 32'(in_ready), 1);

        cyc(0, 1, 0, MIPS_ADD, 32'h100, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("mips_valid", 32'(out_valid), 1);
        chk("mips_passthru", 32'(passthru), 1);
        chk("mips_last", 32'(uop_last), 1);
        chk("mips_in_ready", 32'(in_ready), 1);
        chk("mips_pc", held_pc, 32'h100);

        cyc(0, 1, 1, POPL_EAX, 32'h200, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("popl0_ra", 32'(ra), 5);
        chk("popl0_rn", 32'(rn), 1);
        chk("popl0_m2reg", 32'(m2reg), 1);
        chk("popl0_in_ready", 32'(in_ready), 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("popl1_ra", 32'(ra), 5);
        chk("popl1_rn", 32'(rn), 5);
        chk("popl1_imm", imm, 4);
        chk("popl1_aluc", 32'(aluc), 32'(ALU_ADD));
        chk("popl1_last", 32'(uop_last), 1);

        cyc(0, 1, 1, POPL_ESP, 32'h300, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("poplesp_rn", 32'(rn), 5);
        chk("poplesp_last", 32'(uop_last), 1);
        chk("poplesp_passthru", 32'(passthru), 0);

        cyc(0, 1, 1, Y86_LEAVE, 32'h400, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("leave_idx_a", 32'(uop_idx), 0);
`ifdef Y86_LEAVE_EN
        chk("leave0_ra", 32'(ra), 6);
        cyc(0, 0, 0, 0, 0, 0);
        chk("leave_idx_b", 32'(uop_idx), 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("leave_idx_c", 32'(uop_idx), 1);
        chk("leave1_rn", 32'(rn), 6);
        cyc(0, 0, 0, 0, 0, 1);
        chk("leave_idx_d", 32'(uop_idx), 2);
        chk("leave2_imm", imm, 4);
`else
        chk("leave_passthru", 32'(passthru), 1);
        chk("leave_last", 32'(uop_last), 1);
`endif
        cyc(0, 0, 0, 0, 0, 1);

        cyc(0, 1, 1, POPL_ECX, 32'h500, 1);
        cyc(0, 1, 1, Y86_NOP, 32'h504, 1);
        chk("b2b_idx0", 32'(uop_idx), 0);
        chk("b2b_rn", 32'(rn), 2);
        cyc(0, 1, 1, Y86_NOP, 32'h504, 1);
        chk("b2b_idx1", 32'(uop_idx), 1);
        chk("b2b_ready", 32'(in_ready), 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("b2b_nop_valid", 32'(out_valid), 1);
        chk("b2b_nop_idx", 32'(uop_idx), 0);
        chk("b2b_nop_pc", held_pc, 32'h504);

        cyc(0, 1, 1, POPL_EAX, 32'h600, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rstmid_valid_pre", 32'(out_valid), 1);
        reset = 1'b1;
        #1;
        chk("rstmid_valid", 32'(out_valid), 0);
        chk("rstmid_idx", 32'(uop_idx), 0);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rstmid_no_uop1_a", 32'(out_valid), 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rstmid_no_uop1_b", 32'(out_valid), 0);

        for (int i = 0; i < 800; i++) begin
            x = {16'($urandom), 32'($urandom)};
            case ($urandom_range(0, 3))
                0: x[7:4] = 4'hB;
                1: x[7:4] = 4'hF;
                2: ;
                default: begin x[7:4] = 4'hB; x[15:12] = 4'h4; end
            endcase
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 3) != 0), x, $urandom, ($urandom_range(0, 3) != 0));
        end
        cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/y86_uop_seq.md
Y86_UOP_SEQ -- requirements
Module: y86_uop_seq

Interface
REQ-001 Parameter REG_OFS, default 1: offset added to a 4-bit Y86 register field to form a 5-bit register-file index.
REQ-002 Parameter R_ESP_IDX, default 5: register-file index of %esp.
REQ-003 Parameter R_EBP_IDX, default 6: register-file index of %ebp.
REQ-004 Parameter OP_LEAVE, default 4'hF: Y86 opcode of LEAVE.
REQ-005 Ports (clock and reset first):
- clk, input, 1: clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: inst/mode/next_inst_pc valid.
- in_ready, output, 1: block accepts an instruction this cycle.
- mode, input, 1: 0 = MIPS, 1 = Y86.
- inst, input, 48: raw instruction bytes, Y86 op at [7:4], rA at [15:12].
- next_inst_pc, input, 32: PC of the following instruction.
- out_valid, output, 1: micro-op fields valid.
- out_ready, input, 1: downstream consumes the micro-op.
- uop_idx, output, 2: index of the current micro-op within its instruction.
- uop_last, output, 1: current micro-op is the final one.
- passthru, output, 1: the single-uop instruction is decoded downstream; other fields are don't-care.
- ra, output, 5: ALU A source register.
- rn, output, 5: destination register.
- aluc, output, 4: ALU operation, using the common ALU codes.
- imm, output, 32: immediate operand.
- useimm, output, 1: B operand = imm.
- m2reg, output, 1: writeback from memory.
- wreg, output, 1: register write enable.
- held_pc, output, 32: next_inst_pc latched with the held instruction.

Function
REQ-006 The block SHALL hold at most one instruction: IDLE = empty, ISSUE = holding.
REQ-007 in_ready SHALL be 1 in IDLE, or in ISSUE when out_ready=1 and uop_last=1; otherwise 0.
REQ-008 Accept (in_valid & in_ready) SHALL latch mode, inst, and next_inst_pc, set uop_idx=0, and enter ISSUE; the first micro-op appears the next cycle (latency 1).
REQ-009 out_valid SHALL equal (state == ISSUE).
REQ-010 A handshake (out_valid & out_ready) on a non-last uop SHALL increment uop_idx; out_valid=1 & out_ready=0 SHALL hold all outputs stable.
REQ-011 A handshake on the last uop SHALL, in the same edge, accept the next instruction if in_valid=1 (zero-bubble back-to-back); otherwise it SHALL go IDLE.
REQ-012 The micro-op count per instruction SHALL be:
- MIPS: 1.
- Y86 non-POPL/non-LEAVE: 1.
- POPL with rA+REG_OFS == R_ESP_IDX: 1.
- POPL otherwise: 2.
- LEAVE: 3.
REQ-013 For 1-uop instructions other than POPL-to-%esp, the block SHALL assert passthru=1.
REQ-014 POPL uop0 (and the sole uop of POPL-to-%esp):
- ra=R_ESP_IDX, rn=rA+REG_OFS, aluc=ALU_OR.
- imm=0, useimm=1, m2reg=1, wreg=1.
REQ-015 POPL uop1: ra=rn=R_ESP_IDX, aluc=ALU_ADD, imm=4, useimm=1, m2reg=0, wreg=1.
REQ-016 LEAVE micro-ops:
- uop0: ra=R_EBP_IDX, rn=R_ESP_IDX, ALU_OR, imm=0, useimm=1, wreg=1.
- uop1: ra=R_ESP_IDX, rn=R_EBP_IDX, ALU_OR, imm=0, useimm=1, m2reg=1, wreg=1.
- uop2: same as POPL uop1.
REQ-017 Register-index arithmetic SHALL be 5-bit and wrap modulo 32.
REQ-018 Outputs not listed for a micro-op SHALL be 0.

Reset
REQ-019 While reset=1, regardless of clk, the block SHALL force:
- state IDLE, uop_idx=0, out_valid=0.
- all registered instruction and PC fields 0.
- in_ready=1 after release.
REQ-020 Reset mid-sequence SHALL abandon remaining micro-ops; no micro-op SHALL be re-emitted after release.

Configuration
REQ-021 With macro Y86_LEAVE_EN defined, LEAVE SHALL expand per REQ-016.
REQ-022 Without Y86_LEAVE_EN, OP_LEAVE SHALL be a 1-uop passthru instruction and no LEAVE logic SHALL be synthesised.

Verification
REQ-023 Reset, then MIPS add with in_valid=1 and out_ready=1 -> one uop next cycle with passthru=1, uop_last=1, in_ready=1.
REQ-024 Y86 popl %eax (inst[15:12]=0) with out_ready=1:
- uop0: ra=5, rn=1, m2reg=1.
- uop1: ra=rn=5, imm=4, ALU_ADD.
- in_ready=0 during uop0.
REQ-025 popl %esp (rA=4) -> single uop with rn=5, uop_last=1, passthru=0.
REQ-026 LEAVE with Y86_LEAVE_EN and out_ready toggling 1,0,1,1 -> uop_idx sequence 0,1,1,2; outputs stable while stalled.
REQ-027 Back-to-back popl %ecx then nop, with in_valid held high -> uops with uop_idx 0, 1, 0 on consecutive cycles and no bubble.
REQ-028 Assert reset during popl uop0 -> out_valid=0 immediately; after release, no uop1 is emitted.
